// File: rtl/supercar_pkg.sv
// Shared types and constants for the supercar (bouncing light) register driver.
package supercar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int N_BIT_DEF = 4;
  localparam int DIV_DEF   = 4;
  localparam int SPEED_W   = 2;

endpackage

// File: rtl/supercar_driver_tick_gen.sv
// Prescaler for the supercar driver: counts 0..div-1 while run is high and
// pulses tick on the last count; clr restarts the count from 0.
module tick_gen #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          run,
  input  logic [DW-1:0] div,
  output logic          tick
);

  logic [DW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == (div - DW'(1)));
  assign tick   = run && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || !run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/supercar_driver.sv
// Drives an external bouncing shift register: seeds a trail of lit bits, then
// keeps shifting while modelling the head position. SUPERCAR_DRIVER_SPEED_EN adds a speed port.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for start; register untouched
// ST_SEED  | shifting in ones, one per tick, trail times
// ST_RUN   | shifting in zeros, one per tick, until stop
// ST_CLEAR | one-cycle clear pulse to the register
module supercar_driver
  import supercar_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF,
  parameter int DIV   = DIV_DEF,
  parameter int TW    = $clog2(N_BIT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [TW-1:0]            trail,
`ifdef SUPERCAR_DRIVER_SPEED_EN
  input  logic [SPEED_W-1:0]       speed,
`endif
  output logic                     shr_en,
  output logic                     shr_sin,
  output logic                     shr_clr,
  output logic                     busy,
  output logic [$clog2(N_BIT)-1:0] pos,
  output logic                     dir
);

  localparam int PW = $clog2(N_BIT);
  localparam int DW = $clog2((DIV << 3) + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_seed_left;
  logic [PW-1:0]   r_pos;
  logic            r_dir;
  logic            r_first;
  logic [PW-1:0]   w_trail_lat;
  logic [PW-1:0]   w_pos_nxt;
  logic            w_dir_nxt;
  logic            w_accept;
  logic            w_run;
  logic            w_tick;
  logic [DW-1:0]   w_div;

`ifdef SUPERCAR_DRIVER_SPEED_EN
  logic [DW-1:0]   r_div;
  assign w_div = r_div;
`else
  assign w_div = DW'(DIV);
`endif

  assign w_accept = (r_state == ST_IDLE) && start && !stop;
  assign w_run    = (r_state == ST_SEED) || (r_state == ST_RUN);
  assign pos      = r_pos;
  assign dir      = r_dir;

  tick_gen #(.DW(DW)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_state_nxt != r_state),
    .run  (w_run),
    .div  (w_div),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SEED;
      ST_SEED: begin
        if (stop)                                    w_state_nxt = ST_CLEAR;
        else if (w_tick && r_seed_left == PW'(1))    w_state_nxt = ST_RUN;
      end
      ST_RUN:   if (stop) w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // stop beats a coincident tick so the register never shifts on the way out
  always_comb begin
    shr_en  = w_run && w_tick && !stop;
    shr_sin = shr_en && (r_state == ST_SEED);
    shr_clr = (r_state == ST_CLEAR);
    busy    = (r_state != ST_IDLE);
  end

  always_comb begin
    w_trail_lat = PW'(trail);
    if (trail == '0)                w_trail_lat = PW'(1);
    else if (int'(trail) > N_BIT-1) w_trail_lat = PW'(N_BIT - 1);
  end

  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (!r_dir) begin
      if (r_pos == PW'(N_BIT - 1)) begin
        w_dir_nxt = 1'b1;
        w_pos_nxt = PW'(N_BIT - 2);
      end else begin
        w_pos_nxt = r_pos + PW'(1);
      end
    end else begin
      if (r_pos == '0) begin
        w_dir_nxt = 1'b0;
        w_pos_nxt = PW'(1);
      end else begin
        w_pos_nxt = r_pos - PW'(1);
      end
    end
  end

  // the first seed tick lights the head at 0, so movement starts on the second
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seed_left <= PW'(1);
      r_pos       <= '0;
      r_dir       <= 1'b0;
      r_first     <= 1'b0;
`ifdef SUPERCAR_DRIVER_SPEED_EN
      r_div       <= DW'(DIV);
`endif
    end else if (w_accept) begin
      r_seed_left <= w_trail_lat;
      r_pos       <= '0;
      r_dir       <= 1'b0;
      r_first     <= 1'b1;
`ifdef SUPERCAR_DRIVER_SPEED_EN
      r_div       <= DW'(DIV) << speed;
`endif
    end else if (shr_en) begin
      r_first <= 1'b0;
      if (!r_first) begin
        r_pos <= w_pos_nxt;
        r_dir <= w_dir_nxt;
      end
      if (r_state == ST_SEED) r_seed_left <= r_seed_left - PW'(1);
    end
  end

endmodule
